// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: control-unit state encoding, opcode constants and the strobe bundle.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_OPR_HI, S_OPR_LO, S_IMM, S_MEM_RD,
        S_MEM_WR, S_WB_TR, S_JUMP, S_ALU_EX, S_ALU_WB
    } state_e;

    localparam logic [2:0] OP_LDR = 3'b000;
    localparam logic [2:0] OP_STR = 3'b001;
    localparam logic [2:0] OP_JMP = 3'b010;
    localparam logic [2:0] OP_JZ  = 3'b011;
    localparam logic [2:0] OP_JC  = 3'b100;
    localparam logic [2:0] OP_MVI = 3'b101;
    localparam logic [1:0] OP_ALU = 2'b11;

    typedef struct packed {
        logic ld_ir;
        logic ld_di;
        logic cen_pc;
        logic ld_pc;
        logic ld_tr_12_8;
        logic ld_tr_7_0;
        logic mem_src_pc;
        logic mem_src_tr;
        logic mem_write;
        logic sel_ir_3_2;
        logic sel_ir_4_3;
        logic write_reg_en;
        logic rf_src_tr;
        logic rf_src_alu;
        logic alu_src_reg1;
        logic ld_alu;
        logic ld_czn;
        logic czn_src_rf;
        logic czn_src_alu;
        logic instr_done;
    } ctrl_t;

    function automatic logic is_alu(input logic [2:0] op);
        return op[2:1] == OP_ALU;
    endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the 8-bit CPU; strobes decode from the state register.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [2:0] czn,
    output logic       ld_IR,
    output logic       ld_DI,
    output logic       cen_PC,
    output logic       ld_PC,
    output logic       ld_TR_12_8,
    output logic       ld_TR_7_0,
    output logic       sel_MEM_src_PC,
    output logic       sel_MEM_src_TR,
    output logic       mem_write,
    output logic       sel_IR_3_2,
    output logic       sel_IR_4_3,
    output logic       write_reg_en,
    output logic       sel_RF_write_src_TR_7_0,
    output logic       sel_writeSRC_ALU,
    output logic       sel_ALU_src_reg1,
    output logic       ld_ALU,
    output logic       ld_CZN,
    output logic       sel_CZN_src_RF,
    output logic       sel_CZN_src_ALU,
    output logic       instr_done
);

    state_e state_q, state_d;
    ctrl_t  c, o;
    logic   unused_n;

    assign unused_n = czn[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        c       = '0;
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                c.mem_src_pc = 1'b1;
                c.ld_ir      = 1'b1;
                c.ld_di      = 1'b1;
                c.cen_pc     = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: state_d = is_alu(opcode) ? S_ALU_EX : (opcode == OP_MVI) ? S_IMM : S_OPR_HI;
            S_OPR_HI: begin
                c.mem_src_pc = 1'b1;
                c.ld_tr_12_8 = 1'b1;
                c.cen_pc     = 1'b1;
                state_d      = S_OPR_LO;
            end
            S_OPR_LO: begin
                c.mem_src_pc = 1'b1;
                c.ld_tr_7_0  = 1'b1;
                c.cen_pc     = 1'b1;
                state_d      = (opcode == OP_LDR) ? S_MEM_RD :
                               (opcode == OP_STR) ? S_MEM_WR :
                               (opcode inside {OP_JMP, OP_JZ, OP_JC}) ? S_JUMP : S_FETCH;
            end
            S_IMM: begin
                c.mem_src_pc = 1'b1;
                c.ld_tr_7_0  = 1'b1;
                c.cen_pc     = 1'b1;
                state_d      = S_WB_TR;
            end
            S_MEM_RD: begin
                c.mem_src_tr = 1'b1;
                c.ld_tr_7_0  = 1'b1;
                state_d      = S_WB_TR;
            end
            S_WB_TR: begin
                c.sel_ir_4_3   = 1'b1;
                c.rf_src_tr    = 1'b1;
                c.write_reg_en = 1'b1;
                c.ld_czn       = 1'b1;
                c.czn_src_rf   = 1'b1;
                c.instr_done   = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_src_tr = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            // Branch condition looks at the flags only while in JUMP.
            S_JUMP: begin
                c.ld_pc      = (opcode == OP_JMP) | ((opcode == OP_JZ) & czn[1]) | ((opcode == OP_JC) & czn[0]);
                c.instr_done = 1'b1;
            end
            S_ALU_EX: begin
                c.alu_src_reg1 = 1'b1;
                c.ld_alu       = 1'b1;
                state_d        = S_ALU_WB;
            end
            S_ALU_WB: begin
                c.sel_ir_3_2   = 1'b1;
                c.rf_src_alu   = 1'b1;
                c.write_reg_en = 1'b1;
                c.ld_czn       = 1'b1;
                c.czn_src_alu  = 1'b1;
                c.instr_done   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset silences every strobe immediately, not just at the next edge.
    assign o = rst ? c : '0;

    assign ld_IR                   = o.ld_ir;
    assign ld_DI                   = o.ld_di;
    assign cen_PC                  = o.cen_pc;
    assign ld_PC                   = o.ld_pc;
    assign ld_TR_12_8              = o.ld_tr_12_8;
    assign ld_TR_7_0               = o.ld_tr_7_0;
    assign sel_MEM_src_PC          = o.mem_src_pc;
    assign sel_MEM_src_TR          = o.mem_src_tr;
    assign mem_write               = o.mem_write;
    assign sel_IR_3_2              = o.sel_ir_3_2;
    assign sel_IR_4_3              = o.sel_ir_4_3;
    assign write_reg_en            = o.write_reg_en;
    assign sel_RF_write_src_TR_7_0 = o.rf_src_tr;
    assign sel_writeSRC_ALU        = o.rf_src_alu;
    assign sel_ALU_src_reg1        = o.alu_src_reg1;
    assign ld_ALU                  = o.ld_alu;
    assign ld_CZN                  = o.ld_czn;
    assign sel_CZN_src_RF          = o.czn_src_rf;
    assign sel_CZN_src_ALU         = o.czn_src_alu;
    assign instr_done              = o.instr_done;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: instruction-level model of the strobe sequence checked every cycle, plus literal spot checks.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [2:0] czn = 3'b000;
    logic ld_IR, ld_DI, cen_PC, ld_PC, ld_TR_12_8, ld_TR_7_0;
    logic sel_MEM_src_PC, sel_MEM_src_TR, mem_write;
    logic sel_IR_3_2, sel_IR_4_3, write_reg_en;
    logic sel_RF_write_src_TR_7_0, sel_writeSRC_ALU, sel_ALU_src_reg1, ld_ALU;
    logic ld_CZN, sel_CZN_src_RF, sel_CZN_src_ALU, instr_done;

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .czn(czn),
        .ld_IR(ld_IR), .ld_DI(ld_DI), .cen_PC(cen_PC), .ld_PC(ld_PC),
        .ld_TR_12_8(ld_TR_12_8), .ld_TR_7_0(ld_TR_7_0),
        .sel_MEM_src_PC(sel_MEM_src_PC), .sel_MEM_src_TR(sel_MEM_src_TR), .mem_write(mem_write),
        .sel_IR_3_2(sel_IR_3_2), .sel_IR_4_3(sel_IR_4_3), .write_reg_en(write_reg_en),
        .sel_RF_write_src_TR_7_0(sel_RF_write_src_TR_7_0), .sel_writeSRC_ALU(sel_writeSRC_ALU),
        .sel_ALU_src_reg1(sel_ALU_src_reg1), .ld_ALU(ld_ALU),
        .ld_CZN(ld_CZN), .sel_CZN_src_RF(sel_CZN_src_RF), .sel_CZN_src_ALU(sel_CZN_src_ALU),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    localparam logic [19:0] M_LDIR   = 20'h80000;
    localparam logic [19:0] M_LDDI   = 20'h40000;
    localparam logic [19:0] M_CEN    = 20'h20000;
    localparam logic [19:0] M_LDPC   = 20'h10000;
    localparam logic [19:0] M_TR128  = 20'h08000;
    localparam logic [19:0] M_TR70   = 20'h04000;
    localparam logic [19:0] M_MPC    = 20'h02000;
    localparam logic [19:0] M_MTR    = 20'h01000;
    localparam logic [19:0] M_MEMW   = 20'h00800;
    localparam logic [19:0] M_IR32   = 20'h00400;
    localparam logic [19:0] M_IR43   = 20'h00200;
    localparam logic [19:0] M_WE     = 20'h00100;
    localparam logic [19:0] M_RFTR   = 20'h00080;
    localparam logic [19:0] M_WSALU  = 20'h00040;
    localparam logic [19:0] M_ALUSRC = 20'h00020;
    localparam logic [19:0] M_LDALU  = 20'h00010;
    localparam logic [19:0] M_LDCZN  = 20'h00008;
    localparam logic [19:0] M_CZRF   = 20'h00004;
    localparam logic [19:0] M_CZALU  = 20'h00002;
    localparam logic [19:0] M_DONE   = 20'h00001;

    logic [19:0] dut_v;
    assign dut_v = {ld_IR, ld_DI, cen_PC, ld_PC, ld_TR_12_8, ld_TR_7_0,
                    sel_MEM_src_PC, sel_MEM_src_TR, mem_write,
                    sel_IR_3_2, sel_IR_4_3, write_reg_en,
                    sel_RF_write_src_TR_7_0, sel_writeSRC_ALU, sel_ALU_src_reg1, ld_ALU,
                    ld_CZN, sel_CZN_src_RF, sel_CZN_src_ALU, instr_done};

    int n_chk = 0;
    int n_fail = 0;
    bit exp_on = 1'b0;
    logic [19:0] exp_v = '0;
    int cur_k = 0;
    int done_cnt = 0;
    logic [19:0] cap [1:6];

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", nm, act, req);
        end
    endtask

    function automatic int ilen(input logic [2:0] op);
        return (op[2:1] == 2'b11 || op == 3'b101) ? 4 : (op == 3'b000) ? 6 : 5;
    endfunction

    // Expected strobes for cycle k (1 = FETCH) of an instruction, from its byte layout.
    function automatic logic [19:0] model(input logic [2:0] op, input logic [2:0] f, input int k);
        logic [19:0] wb_tr;
        logic taken;
        wb_tr = M_IR43 | M_RFTR | M_WE | M_LDCZN | M_CZRF | M_DONE;
        taken = (op == 3'b010) || (op == 3'b011 && f[1]) || (op == 3'b100 && f[0]);
        if (k == 1) return M_MPC | M_LDIR | M_LDDI | M_CEN;
        if (k == 2) return '0;
        if (op[2:1] == 2'b11)
            return (k == 3) ? (M_ALUSRC | M_LDALU) : (M_IR32 | M_WSALU | M_WE | M_LDCZN | M_CZALU | M_DONE);
        if (op == 3'b101) return (k == 3) ? (M_MPC | M_TR70 | M_CEN) : wb_tr;
        if (k == 3) return M_MPC | M_TR128 | M_CEN;
        if (k == 4) return M_MPC | M_TR70 | M_CEN;
        if (op == 3'b000) return (k == 5) ? (M_MTR | M_TR70) : wb_tr;
        if (op == 3'b001) return M_MTR | M_MEMW | M_DONE;
        return (taken ? M_LDPC : 20'h0) | M_DONE;
    endfunction

    always @(negedge clk) begin
        if (exp_on) begin
            chk($sformatf("cycle k=%0d op=%03b czn=%03b", cur_k, opcode, czn), dut_v, exp_v);
            chk("exclusive_pairs",
                {15'b0, dut_v[13] & dut_v[12], dut_v[10] & dut_v[9], dut_v[7] & dut_v[6],
                 dut_v[2] & dut_v[1], dut_v[16] & dut_v[17]}, 20'h0);
            if (cur_k >= 1 && cur_k <= 6) cap[cur_k] = dut_v;
            if (dut_v[0]) done_cnt++;
        end
    end

    task automatic run(input logic [2:0] op, input logic [2:0] f);
        opcode = op;
        czn = f;
        done_cnt = 0;
        for (int k = 1; k <= ilen(op); k++) begin
            cur_k = k;
            exp_v = model(op, f, k);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        exp_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", dut_v, 20'h0);
        rst = 1'b1;

        run(3'b110, 3'b000);
        chk("alu_ex", cap[3], M_ALUSRC | M_LDALU);
        chk("alu_wb_we", cap[4] & (M_WE | M_IR32), M_WE | M_IR32);
        chk("alu_done_count", 20'(done_cnt), 20'd1);

        run(3'b101, 3'b000);
        chk("mvi_cen", {16'b0, cap[1][17], cap[2][17], cap[3][17], cap[4][17]}, 20'b1010);
        chk("mvi_wb", cap[4], M_IR43 | M_RFTR | M_WE | M_LDCZN | M_CZRF | M_DONE);

        run(3'b011, 3'b010);
        chk("jz_taken", cap[5], M_LDPC | M_DONE);
        run(3'b011, 3'b000);
        chk("jz_not_taken", cap[5], M_DONE);
        run(3'b100, 3'b001);
        chk("jc_taken", cap[5], M_LDPC | M_DONE);
        run(3'b010, 3'b000);
        chk("jmp", cap[5], M_LDPC | M_DONE);

        run(3'b000, 3'b000);
        chk("ldr_mem_rd", cap[5], M_MTR | M_TR70);
        chk("ldr_done_count", 20'(done_cnt), 20'd1);
        run(3'b001, 3'b000);
        chk("str_mem_wr", cap[5], M_MTR | M_MEMW | M_DONE);
        chk("str_no_early_write", {16'b0, cap[1][11], cap[2][11], cap[3][11], cap[4][11]}, 20'h0);

        opcode = 3'b000;
        czn = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cur_k = k;
            exp_v = model(3'b000, 3'b000, k);
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        #2;
        exp_v = '0;
        cur_k = 0;
        rst = 1'b0;
        #1;
        chk("async_reset_mid_ldr", dut_v, 20'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(3'b000, 3'b000);
        chk("fetch_after_reset", cap[1], M_MPC | M_LDIR | M_LDDI | M_CEN);

        repeat (1000) run(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

        exp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL take no parameters; all widths are fixed: 3-bit opcode and 3-bit flags.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 opcode  in  3  IR[7:5] from data path; valid from DECODE onward.
REQ-005 czn  in  3  flag register contents; bit0=C, bit1=Z, bit2=N.
REQ-006 ld_IR, ld_DI, cen_PC, ld_PC  out  1 each  instruction-register load, DI load, PC increment, PC load from TR.
REQ-007 ld_TR_12_8, ld_TR_7_0  out  1 each  TR high-5 / low-8 load from memory data.
REQ-008 sel_MEM_src_PC, sel_MEM_src_TR, mem_write  out  1 each  memory address source (one-hot) and write strobe.
REQ-009 sel_IR_3_2, sel_IR_4_3, write_reg_en  out  1 each  RF destination field select (one-hot) and write enable.
REQ-010 sel_RF_write_src_TR_7_0, sel_writeSRC_ALU  out  1 each  RF write-data source (one-hot).
REQ-011 sel_ALU_src_reg1, ld_ALU  out  1 each  ALU operand-1 select, ALU result register load.
REQ-012 ld_CZN, sel_CZN_src_RF, sel_CZN_src_ALU  out  1 each  flag load and flag-source select (one-hot).
REQ-013 instr_done  out  1  one-cycle pulse in final state of every instruction.

Function
REQ-014 Opcodes SHALL be: 000 LDR, 001 STR, 010 JMP, 011 JZ, 100 JC, 101 MVI, 11x ALU (op in IR[5:4], Rd=IR[3:2], Rs=IR[1:0]).
REQ-015 LDR/STR/JMP/JZ/JC SHALL be 3 bytes (opcode, addr[12:8] in bits 4:0, addr[7:0]); MVI 2 bytes (opcode with Rd=IR[4:3], imm8); ALU 1 byte.
REQ-016 Moore FSM states: FETCH, DECODE, OPR_HI, OPR_LO, IMM, MEM_RD, MEM_WR, WB_TR, JUMP, ALU_EX, ALU_WB.
REQ-017 FETCH: sel_MEM_src_PC, ld_IR, ld_DI, cen_PC; next DECODE.
REQ-018 DECODE: no strobes; next ALU_EX (11x), IMM (101), else OPR_HI.
REQ-019 OPR_HI: sel_MEM_src_PC, ld_TR_12_8, cen_PC; next OPR_LO.
REQ-020 OPR_LO: sel_MEM_src_PC, ld_TR_7_0, cen_PC; next MEM_RD (LDR), MEM_WR (STR), JUMP (010/011/100).
REQ-021 IMM: sel_MEM_src_PC, ld_TR_7_0, cen_PC; next WB_TR.
REQ-022 MEM_RD: sel_MEM_src_TR, ld_TR_7_0; next WB_TR.
REQ-023 WB_TR: sel_IR_4_3, sel_RF_write_src_TR_7_0, write_reg_en, ld_CZN, sel_CZN_src_RF, instr_done; next FETCH.
REQ-024 MEM_WR: sel_MEM_src_TR, mem_write, instr_done; next FETCH.
REQ-025 JUMP: ld_PC = 1 for JMP, czn[1] for JZ, czn[0] for JC; instr_done; next FETCH; cen_PC SHALL be 0.
REQ-026 ALU_EX: sel_ALU_src_reg1, ld_ALU; next ALU_WB.
REQ-027 ALU_WB: sel_IR_3_2, sel_writeSRC_ALU, write_reg_en, ld_CZN, sel_CZN_src_ALU, instr_done; next FETCH.
REQ-028 Latency (cycles incl. FETCH): ALU 4, MVI 4, STR 5, JMP/JZ/JC 5, LDR 6.
REQ-029 Every output not listed for a state SHALL be 0; one-hot select pairs SHALL never both be 1; ld_PC and cen_PC SHALL never both be 1.
REQ-030 Branch condition SHALL sample czn in JUMP state only; flags written by the same instruction are impossible (jumps never load CZN).
REQ-031 Unknown/X opcode in DECODE SHALL not occur (all 8 codes defined); illegal state encodings SHALL recover to FETCH.

Reset
REQ-032 While rst=0 state SHALL be FETCH and all outputs forced 0, including instr_done.
REQ-033 Reset asserted mid-instruction SHALL abort it immediately with no further strobes; first FETCH strobes appear in the first cycle after rst deasserts.

Structure
REQ-034 Package cpu_ctrl_pkg SHALL hold the state enum and opcode constants; data path shares the opcode constants.
REQ-035 No sub-module: one state register plus combinational next-state/output decode.

Verification
REQ-036 ALU byte 0xC6 (ADD R1,R2) -> FETCH,DECODE,ALU_EX,ALU_WB; write_reg_en+sel_IR_3_2 in cycle 4; instr_done once.
REQ-037 MVI 0xA8,0x5A -> cen_PC in cycles 1 and 3; WB_TR in cycle 4 with sel_IR_4_3, ld_CZN, sel_CZN_src_RF.
REQ-038 JZ 0x61,0x23 with czn=3'b010 -> ld_PC=1 in cycle 5; repeat with czn=3'b000 -> ld_PC=0, cen_PC=0.
REQ-039 LDR then STR back-to-back -> 6 then 5 cycles, mem_write only in STR cycle 5, sel_MEM_src_TR in LDR cycle 5.
REQ-040 rst pulled low during LDR OPR_LO -> all outputs 0 asynchronously; after release FETCH strobes next cycle.
REQ-041 Random opcode stream (1000 instrs) -> one-hot and ld_PC/cen_PC exclusivity assertions never fire.
